// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and helpers for the Ibex memory responder.
//   resp_t         : one response slot {valid, rdata, err}
//   MaxRespLatency : deepest response pipeline supported
//   in_range()     : byte-address decode against a word-array window
package ibex_mem_resp_pkg;

   localparam int MaxRespLatency = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   // The upper bound is computed in 33 bits so a window ending exactly at
   // 2^32 still decodes its last word correctly.
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int          words);
      logic [32:0] limit;
      limit = {1'b0, base} + (33'(words) * 33'd4);
      return (addr >= base) && ({1'b0, addr} < limit);
   endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-depth response delay line for the memory responder.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the valid bits only
//   head  : response entering stage 0 at each rising edge
//   tail  : response leaving the last stage
module ibex_mem_resp_pipe
   import ibex_mem_resp_pkg::*;
#(
   parameter int RespLatency = 1
) (
   input  logic  clk,
   input  logic  rst_n,
   input  resp_t head,
   output resp_t tail
);

   // Stages are packed side by side; bit/word 0 is stage 0, the top slice
   // is the last stage. Shifting left advances every stage by one.
   logic [RespLatency-1:0]    vld_p;
   logic [32*RespLatency-1:0] rdata_p;
   logic [RespLatency-1:0]    err_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
      end else begin
         vld_p <= (vld_p << 1) | RespLatency'(head.valid);
      end
   end

   // Payload is qualified by the valid bit, so it needs no reset.
   always_ff @(posedge clk) begin
      rdata_p <= (rdata_p << 32) | (32*RespLatency)'(head.rdata);
      err_p   <= (err_p << 1) | RespLatency'(head.err);
   end

   assign tail = '{valid: vld_p[RespLatency-1],
                   rdata: rdata_p[32*RespLatency-1 -: 32],
                   err:   err_p[RespLatency-1]};

endmodule

// File: rtl/ibex_mem_responder.sv
// Single-port memory responder for the Ibex req/gnt/rvalid bus.
// Grants requests, performs byte-enabled writes into a local word array and
// returns read data / errors in grant order after RespLatency cycles.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   req_i, gnt_o       : request / combinational grant
//   addr_i, we_i, be_i : byte address, write enable, byte enables
//   wdata_i            : write data
//   rvalid_o, rdata_o  : response valid / read data (0 when idle or write)
//   err_o              : bus error (out-of-range access)
//   stall_i            : backpressure, forces gnt_o low
module ibex_mem_responder
   import ibex_mem_resp_pkg::*;
#(
   parameter int          MemWords       = 256,
   parameter logic [31:0] BaseAddr       = 32'h0000_0000,
   parameter int          RespLatency    = 1,
   parameter int          MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   input  logic        stall_i
);

   localparam int IdxW = $clog2(MemWords);
   localparam int CntW = $clog2(MaxOutstanding + 1);

   if (MemWords < 4 || (MemWords & (MemWords - 1)) != 0) begin : g_bad_words
      $error("MemWords must be a power of two and at least 4");
   end
   if ((64'(BaseAddr) % (64'(MemWords) * 64'd4)) != 64'd0) begin : g_bad_align
      $error("BaseAddr must be aligned to the memory size");
   end
   if ((64'(BaseAddr) + 64'(MemWords) * 64'd4) > 64'h1_0000_0000) begin : g_bad_wrap
      $error("memory window wraps past the 32-bit address space");
   end
   if (RespLatency < 1 || RespLatency > MaxRespLatency) begin : g_bad_lat
      $error("RespLatency out of range");
   end
   if (MaxOutstanding < 1 || MaxOutstanding > RespLatency + 1) begin : g_bad_out
      $error("MaxOutstanding out of range");
   end

   logic [31:0]     mem [MemWords];
   logic [CntW-1:0] outstanding;
   logic            hit;
   logic [IdxW-1:0] idx;
   logic [31:0]     wmask;
   resp_t           resp_p0;
   resp_t           resp_tail;

   // The full check uses the registered count only, so a response retiring
   // in the same cycle frees the slot one cycle later.
   assign gnt_o = req_i && !stall_i && (outstanding < CntW'(MaxOutstanding));
   assign hit   = in_range(addr_i, BaseAddr, MemWords);
   assign idx   = addr_i[IdxW+1:2];
   assign wmask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

   always_ff @(posedge clk_i) begin
      if (gnt_o && we_i && hit) begin
         mem[idx] <= (mem[idx] & ~wmask) | (wdata_i & wmask);
      end
   end

   // Stage 0: response captured at the grant edge
   assign resp_p0 = '{valid: gnt_o,
                      rdata: (gnt_o && !we_i && hit) ? mem[idx] : 32'h0,
                      err:   !hit};

   ibex_mem_resp_pipe #(
      .RespLatency(RespLatency)
   ) u_pipe (
      .clk  (clk_i),
      .rst_n(rst_ni),
      .head (resp_p0),
      .tail (resp_tail)
   );

   // Output: last stage, payload forced to 0 when no response is issued
   assign rvalid_o = resp_tail.valid;
   assign rdata_o  = resp_tail.valid ? resp_tail.rdata : 32'h0;
   assign err_o    = resp_tail.valid && resp_tail.err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding <= '0;
      end else if (gnt_o && !rvalid_o) begin
         outstanding <= outstanding + 1'b1;
      end else if (!gnt_o && rvalid_o) begin
         outstanding <= outstanding - 1'b1;
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      rvalid_o |-> (outstanding != '0));

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_i && !gnt_o) |=> (req_i && $stable({addr_i, we_i, be_i, wdata_i})));

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Self-checking bench for ibex_mem_responder.
// Four instances: 0 = RespLatency 1 / MaxOutstanding 2, 1 = 3 / 2,
// 2 = 4 / 2, 3 = 1 / 1. Only one instance is driven at a time.
module tb_ibex_mem_responder;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [3:0]        req_v = '0;
   logic              stall = 1'b0;
   logic [31:0]       addr = '0;
   logic              we = 1'b0;
   logic [3:0]        be = '0;
   logic [31:0]       wdata = '0;
   logic [3:0]        gnt_v;
   logic [3:0]        rvalid_v;
   logic [3:0]        err_v;
   logic [3:0][31:0]  rdata_v;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      int          inst;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;
   vec_t vecs[11];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      ibex_mem_responder #(
         .MemWords      (256),
         .BaseAddr      (32'h0),
         .RespLatency   (gi == 1 ? 3 : (gi == 2 ? 4 : 1)),
         .MaxOutstanding(gi == 3 ? 1 : 2)
      ) u_dut (
         .clk_i   (clk),
         .rst_ni  (rst_n),
         .req_i   (req_v[gi]),
         .gnt_o   (gnt_v[gi]),
         .addr_i  (addr),
         .we_i    (we),
         .be_i    (be),
         .wdata_i (wdata),
         .rvalid_o(rvalid_v[gi]),
         .rdata_o (rdata_v[gi]),
         .err_o   (err_v[gi]),
         .stall_i (stall)
      );
   end

   function automatic int lat_of(input int i);
      return (i == 1) ? 3 : ((i == 2) ? 4 : 1);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int inst, input logic [31:0] d, input logic e);
      exp_t x;
      x.inst  = inst;
      x.rdata = d;
      x.err   = e;
      x.cyc   = cyc;
      sb.push_back(x);
   endtask

   // Response checker: every rvalid must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (rvalid_v[i]) begin
               if (sb.size() == 0) begin
                  chk($sformatf("unexpected_rvalid_inst%0d", i), 64'(rvalid_v[i]), 64'd0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("resp_inst", 64'(i), 64'(e.inst));
                  chk("resp_rdata", 64'(rdata_v[i]), 64'(e.rdata));
                  chk("resp_err", 64'(err_v[i]), 64'(e.err));
                  chk("resp_latency", 64'(cyc - e.cyc), 64'(lat_of(i)));
               end
            end else begin
               chk($sformatf("idle_rdata_inst%0d", i), 64'(rdata_v[i]), 64'd0);
               chk($sformatf("idle_err_inst%0d", i), 64'(err_v[i]), 64'd0);
            end
         end
      end
   end

   // One transaction: hold the request until granted, then release it.
   task automatic xfer(input int inst, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e);
      int n;
      n = 0;
      req_v[inst] = 1'b1;
      we = w; addr = a; be = b; wdata = d;
      forever begin
         @(negedge clk);
         if (gnt_v[inst]) begin
            push(inst, exp_d, exp_e);
            break;
         end
         n++;
         if (n > 50) begin
            chk("grant_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk); #1;
      req_v[inst] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] gp9, rp9;
      logic [6:0] gp7, rp7;
      int         ngr;
      logic       seen;

      vecs[0]  = '{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'h10,       4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h20,       4'hF, 32'h11223344, 32'h0,        1'b0};
      vecs[3]  = '{1'b1, 32'h20,       4'h5, 32'hAABBCCDD, 32'h0,        1'b0};
      vecs[4]  = '{1'b0, 32'h20,       4'hF, 32'h0,        32'h11BB33DD, 1'b0};
      vecs[5]  = '{1'b1, 32'h0,        4'hF, 32'h01234567, 32'h0,        1'b0};
      vecs[6]  = '{1'b0, 32'h400,      4'hF, 32'h0,        32'h0,        1'b1};
      vecs[7]  = '{1'b1, 32'h400,      4'hF, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[8]  = '{1'b0, 32'h0,        4'hF, 32'h0,        32'h01234567, 1'b0};
      vecs[9]  = '{1'b1, 32'h3FF,      4'hF, 32'h87654321, 32'h0,        1'b0};
      vecs[10] = '{1'b0, 32'h3FC,      4'hF, 32'h0,        32'h87654321, 1'b0};

      // Reset state, with grant following its equation while in reset
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_rvalid", 64'(rvalid_v), 64'd0);
      chk("rst_err", 64'(err_v), 64'd0);
      chk("rst_rdata", 64'(rdata_v), 64'd0);
      req_v[0] = 1'b1;
      #1;
      chk("rst_gnt_req", 64'(gnt_v[0]), 64'd1);
      stall = 1'b1;
      #1;
      chk("rst_gnt_stall", 64'(gnt_v[0]), 64'd0);
      req_v[0] = 1'b0;
      stall = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven transactions on instance 0
      for (int v = 0; v < 11; v++) begin
         xfer(0, vecs[v].we, vecs[v].addr, vecs[v].be, vecs[v].wdata,
              vecs[v].exp_rdata, vecs[v].exp_err);
      end
      xfer(0, 1'b0, 32'hFFFFFFFC, 4'hF, 32'h0, 32'h0, 1'b1);
      drain();

      // Write then read in consecutive cycles: the read sees the new word
      xfer(0, 1'b1, 32'h50, 4'hF, 32'h0BADF00D, 32'h0, 1'b0);
      xfer(0, 1'b0, 32'h50, 4'hF, 32'h0, 32'h0BADF00D, 1'b0);
      drain();

      // Instance 1: full at two outstanding, then stall
      xfer(1, 1'b1, 32'h30, 4'hF, 32'hCAFE0001, 32'h0, 1'b0);
      drain();
      req_v[1] = 1'b1; we = 1'b0; addr = 32'h30; be = 4'hF; wdata = 32'h0;
      ngr = 0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         gp9[c] = gnt_v[1];
         rp9[c] = rvalid_v[1];
         if (gnt_v[1]) begin
            push(1, 32'hCAFE0001, 1'b0);
            ngr++;
         end
         @(posedge clk); #1;
         if (ngr == 3) req_v[1] = 1'b0;
      end
      chk("full_gnt_pattern", 64'(gp9), 64'(9'b000010011));
      chk("full_rvalid_pattern", 64'(rp9), 64'(9'b010011000));
      drain();

      stall = 1'b1;
      req_v[1] = 1'b1; we = 1'b0; addr = 32'h30; be = 4'hF; wdata = 32'h0;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         seen = seen | gnt_v[1] | rvalid_v[1];
         @(posedge clk); #1;
      end
      chk("stall_no_activity", 64'(seen), 64'd0);
      stall = 1'b0;
      @(negedge clk);
      chk("stall_release_gnt", 64'(gnt_v[1]), 64'd1);
      if (gnt_v[1]) push(1, 32'hCAFE0001, 1'b0);
      @(posedge clk); #1;
      req_v[1] = 1'b0;
      drain();

      // Instance 2: reset while two reads are in flight
      xfer(2, 1'b1, 32'h40, 4'hF, 32'h5A5A1234, 32'h0, 1'b0);
      drain();
      req_v[2] = 1'b1; we = 1'b0; addr = 32'h40; be = 4'hF; wdata = 32'h0;
      ngr = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (gnt_v[2]) begin
            push(2, 32'h5A5A1234, 1'b0);
            ngr++;
         end
         @(posedge clk); #1;
      end
      req_v[2] = 1'b0;
      chk("inflight_grants", 64'(ngr), 64'd2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         seen = seen | rvalid_v[2];
      end
      chk("dropped_after_reset", 64'(seen), 64'd0);
      @(posedge clk); #1;
      req_v[2] = 1'b1;
      ngr = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (gnt_v[2]) begin
            push(2, 32'h5A5A1234, 1'b0);
            ngr++;
         end
         @(posedge clk); #1;
      end
      req_v[2] = 1'b0;
      chk("post_reset_two_grants", 64'(ngr), 64'd2);
      drain();

      // Instance 3: one outstanding, grant every other cycle
      xfer(3, 1'b1, 32'h8, 4'hF, 32'h00C0FFEE, 32'h0, 1'b0);
      drain();
      req_v[3] = 1'b1; we = 1'b0; addr = 32'h8; be = 4'hF; wdata = 32'h0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         gp7[c] = gnt_v[3];
         rp7[c] = rvalid_v[3];
         if (gnt_v[3]) push(3, 32'h00C0FFEE, 1'b0);
         @(posedge clk); #1;
         if (c == 6) req_v[3] = 1'b0;
      end
      chk("single_gnt_pattern", 64'(gp7), 64'(7'b1010101));
      chk("single_rvalid_pattern", 64'(rp7), 64'(7'b0101010));
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
